// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: accepts a 128-bit state, mixes one 32-bit column
// per clock through a single shared column datapath, then presents the result.
module inv_mix_columns_seq (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_Valid,
   output logic         o_Ready,
   input  logic [127:0] i_Data,
   output logic         o_Valid,
   input  logic         i_Ready,
   output logic [127:0] o_Data
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [1:0]       col_q, col_d;
   // Column c lives at packed index 3-c so that column 0 is bits [127:96].
   logic [3:0][31:0] buf_q, buf_d;
   logic [3:0][31:0] data_q, data_d;
   logic [31:0]      col_in, col_out;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ ({8{b[7]}} & 8'h1b);
   endfunction

   function automatic logic [31:0] inv_col(input logic [31:0] a);
      logic [7:0] x1 [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      for (int unsigned k = 0; k < 4; k++) begin
         x1[k] = a[31-8*k -: 8];
         x2[k] = xt(x1[k]);
         x4[k] = xt(x2[k]);
         x8[k] = xt(x4[k]);
         m9[k] = x8[k] ^ x1[k];
         mb[k] = x8[k] ^ x2[k] ^ x1[k];
         md[k] = x8[k] ^ x4[k] ^ x1[k];
         me[k] = x8[k] ^ x4[k] ^ x2[k];
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   always_comb begin
      col_in  = buf_q[2'd3 - col_q];
      col_out = inv_col(col_in);
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      buf_d   = buf_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (i_Valid) begin
               buf_d   = i_Data;
               col_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            data_d[2'd3 - col_q] = col_out;
            col_d                = col_q + 2'd1;
            if (col_q == 2'd3) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (i_Ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         col_q   <= '0;
         buf_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         buf_q   <= buf_d;
         data_q  <= data_d;
      end
   end

   assign o_Ready = (state_q == IDLE);
   assign o_Valid = (state_q == DONE);
   assign o_Data  = data_q;

endmodule
